alu_multdiv: RTL and testbench
==============================

# alu_multdiv

Parametrised, registered successor to the processor's combinational ALU. It adds iterative signed multiply and divide to the add/sub/and/or/sll/sra set, and uses a start/busy/ready handshake so the execute stage can stall on long operations. Single-cycle ops return after one clock edge; multiply and divide take WIDTH+2 edges. It sits in the execute stage, and the pipeline freezes while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width (≥4, even).
- `SHAMT_W`, default 5: shift-amount width, ≥ clog2(WIDTH).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `ctrl_start`  in  1  sample operands and opcode on this edge (ignored while `busy`).
- `data_operandA`, `data_operandB`  in  WIDTH  signed two's-complement operands.
- `ctrl_ALUopcode`  in  5  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, 6 mul, 7 div; 8–31 behave as add.
- `ctrl_shiftamt`  in  SHAMT_W  shift amount, used by sll/sra only.
- `data_result`  out  WIDTH  registered result, held until the next completion.
- `isNotEqual`  out  1  registered A≠B for the sampled operands.
- `isLessThan`  out  1  registered signed A<B for the sampled operands; exact, immune to subtract overflow.
- `overflow`  out  1  registered signed overflow for add/sub/mul and for div INT_MIN/−1.
- `data_exception`  out  1  registered divide-by-zero flag.
- `data_resultRDY`  out  1  one-cycle pulse: outputs updated this cycle.
- `busy`  out  1  a mul/div is in flight; start is ignored.

## Operation
- FSM states: IDLE, PREP, ITER, FIX.
- **IDLE, start, opcode ∉ {6,7}.**
  - Compute the result combinationally and register it with the flags.
  - `data_resultRDY`=1 next cycle; stay in IDLE.
- **IDLE, start, opcode 6/7.**
  - Latch A, B and the op; go to PREP; `busy`=1.
  - `isNotEqual` and `isLessThan` update with the result at FIX completion.
- **PREP:** take |A| and |B| into WIDTH-bit unsigned registers.
  - Record the result sign: A[msb]^B[msb] for both mul and div.
  - Clear the accumulator/remainder and the iteration counter; go to ITER.
- **ITER:** WIDTH cycles, one bit per cycle.
  - Mul: radix-2 shift-add into a 2·WIDTH product.
  - Div: restoring shift-subtract, producing the quotient.
  - Counter 0..WIDTH−1; on the last count go to FIX.
- **FIX:** apply the sign, write the outputs, pulse `data_resultRDY`, drop `busy`, return to IDLE.
- **add/sub:**
  - Result wraps modulo 2^WIDTH.
  - `overflow` = operand signs agree (B inverted for sub) and the result sign differs.
- **and/or/sll/sra:** `overflow`=0. sra sign-fills; sll zero-fills. Shift ≥ WIDTH yields 0 (sll), or all sign bits (sra).
- **mul:** `data_result` = low WIDTH bits of the signed product. `overflow`=1 iff the upper WIDTH bits are not the sign-extension of result[msb].
- **div:**
  - Quotient truncates toward zero; the remainder is discarded.
  - B=0: result 0, `data_exception`=1, `overflow`=0. Still takes full latency.
  - A=INT_MIN, B=−1: result INT_MIN, `overflow`=1.
- `data_exception`=0 for every op except div-by-zero.
- Operand inputs may change after the start edge without affecting an in-flight op.

## Timing
- Reset: state IDLE; `data_result`=0; all flags 0; `data_resultRDY`=0; `busy`=0. Reset mid mul/div aborts with no RDY pulse.
- Start is sampled at edge E.
  - Single-cycle ops: outputs and `data_resultRDY` valid after E+1.
  - mul/div: `busy` high after E through E+WIDTH+1; outputs and RDY valid after E+WIDTH+2, with `busy` low in that same cycle.
- Start asserted in the RDY cycle is accepted, giving back-to-back ops with no gap.
- Start while `busy` is dropped, not queued.
- Start held high in IDLE issues one op per edge.
- Outputs change only on a RDY edge or reset.

## Test plan
- Reset mid-op: WIDTH=32, start mul 7×9, assert reset at E+10 → all outputs 0, no RDY pulse. Then add 5+3 → result 8, RDY after E+1, `busy` never high.
- Add overflow: add 0x7FFFFFFF+1 → result 0x80000000, `overflow`=1. Sub 0x80000000−1 → `overflow`=1, `isLessThan`=1. Sub 5−5 → `isNotEqual`=0.
- Shifts: sra 0x80000000 by 4 → 0xF8000000. sll 0x1 by 31 → 0x80000000.
- Multiply: mul −6×7 → −42 (0xFFFFFFD6) after exactly 34 edges, `overflow`=0. mul 0x10000×0x10000 → 0, `overflow`=1.
- Divide: div −7/2 → −3. div 5/0 → 0, `data_exception`=1. div 0x80000000/−1 → 0x80000000, `overflow`=1.
- Handshake: start held during `busy` with a new opcode → ignored. Start in the RDY cycle → the second op's RDY arrives 34 edges later. Also repeat the mul cases with WIDTH=8, expecting 10-edge latency.

Source files
------------

// File: rtl/alu_multdiv_if.sv
// rtl/alu_multdiv_if.sv - execute-stage request/result bundle for alu_multdiv
interface alu_multdiv_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               ctrl_start;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic [4:0]         ctrl_ALUopcode;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [WIDTH-1:0]   data_result;
  logic               isNotEqual;
  logic               isLessThan;
  logic               overflow;
  logic               data_exception;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output ctrl_start, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    input  data_result, isNotEqual, isLessThan, overflow, data_exception,
           data_resultRDY, busy
  );

  modport slave (
    input  ctrl_start, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
    output data_result, isNotEqual, isLessThan, overflow, data_exception,
           data_resultRDY, busy
  );
endinterface

// File: rtl/alu_multdiv.sv
// rtl/alu_multdiv.sv - registered ALU with iterative signed multiply/divide
module alu_multdiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic         clock,
  input logic         reset,
  alu_multdiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int MSB   = WIDTH - 1;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t             state;
  logic               op_is_mul;
  logic               neg;
  logic [WIDTH-1:0]   a_q, b_q, mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   op_a, op_b, sum, diff, sc_res;
  logic               sc_ov, shift_big, start_md;
  assign op_a      = bus.data_operandA;
  assign op_b      = bus.data_operandB;
  assign sum       = op_a + op_b;
  assign diff      = op_a - op_b;
  assign shift_big = 32'(bus.ctrl_shiftamt) >= WIDTH;
  assign start_md  = (bus.ctrl_ALUopcode == OP_MUL) || (bus.ctrl_ALUopcode == OP_DIV);

  always_comb begin
    sc_res = sum;
    sc_ov  = 1'b0;
    case (bus.ctrl_ALUopcode)
      OP_SUB: begin
        sc_res = diff;
        sc_ov  = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      OP_AND: sc_res = op_a & op_b;
      OP_OR:  sc_res = op_a | op_b;
      OP_SLL: sc_res = shift_big ? '0 : op_a << bus.ctrl_shiftamt;
      OP_SRA: sc_res = shift_big ? {WIDTH{op_a[MSB]}} : WIDTH'($signed(op_a) >>> bus.ctrl_shiftamt);
      default: sc_ov = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
    endcase
  end

  // Magnitudes of the latched operands; INT_MIN maps to 2^(WIDTH-1), which fits unsigned.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = a_q[MSB] ? -a_q : a_q;
  assign abs_b = b_q[MSB] ? -b_q : b_q;

  // Mul: prod = {acc, multiplier}; add multiplicand into acc on LSB, shift right.
  logic [WIDTH:0]     mul_acc;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_acc  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_acc, prod[WIDTH-1:1]};

  // Div: prod = {remainder, dividend/quotient}; restoring shift-subtract.
  logic [WIDTH:0]     rem_sh;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign q_bit    = rem_sh >= {1'b0, mcand};
  assign rem_new  = q_bit ? WIDTH'(rem_sh - {1'b0, mcand}) : rem_sh[WIDTH-1:0];
  assign div_next = {rem_new, prod[WIDTH-2:0], q_bit};

  logic [2*WIDTH-1:0] sprod;
  logic [WIDTH-1:0]   squo;
  logic               mul_ov, div_ov;
  assign sprod  = neg ? -prod : prod;
  assign squo   = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
  assign mul_ov = sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[MSB]}};
  assign div_ov = (a_q == INT_MIN) && (b_q == '1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      op_is_mul          <= 1'b0;
      neg                <= 1'b0;
      a_q                <= '0;
      b_q                <= '0;
      mcand              <= '0;
      prod               <= '0;
      cnt                <= '0;
      bus.data_result    <= '0;
      bus.isNotEqual     <= 1'b0;
      bus.isLessThan     <= 1'b0;
      bus.overflow       <= 1'b0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl_start && start_md) begin
            a_q       <= op_a;
            b_q       <= op_b;
            op_is_mul <= bus.ctrl_ALUopcode == OP_MUL;
            bus.busy  <= 1'b1;
            state     <= PREP;
          end else if (bus.ctrl_start) begin
            bus.data_result    <= sc_res;
            bus.overflow       <= sc_ov;
            bus.data_exception <= 1'b0;
            bus.isNotEqual     <= op_a != op_b;
            bus.isLessThan     <= $signed(op_a) < $signed(op_b);
            bus.data_resultRDY <= 1'b1;
          end
        end
        PREP: begin
          mcand <= op_is_mul ? abs_a : abs_b;
          prod  <= {{WIDTH{1'b0}}, (op_is_mul ? abs_b : abs_a)};
          neg   <= a_q[MSB] ^ b_q[MSB];
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          prod <= op_is_mul ? mul_next : div_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_is_mul) begin
            bus.data_result    <= sprod[WIDTH-1:0];
            bus.overflow       <= mul_ov;
            bus.data_exception <= 1'b0;
          end else if (b_q == '0) begin
            bus.data_result    <= '0;
            bus.overflow       <= 1'b0;
            bus.data_exception <= 1'b1;
          end else begin
            bus.data_result    <= squo;
            bus.overflow       <= div_ov;
            bus.data_exception <= 1'b0;
          end
          bus.isNotEqual     <= a_q != b_q;
          bus.isLessThan     <= $signed(a_q) < $signed(b_q);
          bus.data_resultRDY <= 1'b1;
          bus.busy           <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multdiv.sv
// tb/tb_alu_multdiv.sv - self-checking bench for alu_multdiv at WIDTH 32 and 8
module tb_alu_multdiv;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_multdiv_if #(.WIDTH(32), .SHAMT_W(5)) bus32 ();
  alu_multdiv_if #(.WIDTH(8),  .SHAMT_W(3)) bus8 ();

  alu_multdiv #(.WIDTH(32), .SHAMT_W(5)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  alu_multdiv #(.WIDTH(8),  .SHAMT_W(3)) dut8  (.clock(clock), .reset(reset), .bus(bus8));

  logic        use8, start;
  logic [31:0] a_in, b_in;
  logic [4:0]  op_in, sh_in;

  assign bus32.ctrl_start     = start & ~use8;
  assign bus32.data_operandA  = a_in;
  assign bus32.data_operandB  = b_in;
  assign bus32.ctrl_ALUopcode = op_in;
  assign bus32.ctrl_shiftamt  = sh_in;
  assign bus8.ctrl_start      = start & use8;
  assign bus8.data_operandA   = a_in[7:0];
  assign bus8.data_operandB   = b_in[7:0];
  assign bus8.ctrl_ALUopcode  = op_in;
  assign bus8.ctrl_shiftamt   = sh_in[2:0];

  logic [31:0] res_o;
  logic        ov_o, exc_o, ne_o, lt_o, rdy_o, busy_o;
  assign res_o  = use8 ? {24'd0, bus8.data_result} : bus32.data_result;
  assign ov_o   = use8 ? bus8.overflow       : bus32.overflow;
  assign exc_o  = use8 ? bus8.data_exception : bus32.data_exception;
  assign ne_o   = use8 ? bus8.isNotEqual     : bus32.isNotEqual;
  assign lt_o   = use8 ? bus8.isLessThan     : bus32.isLessThan;
  assign rdy_o  = use8 ? bus8.data_resultRDY : bus32.data_resultRDY;
  assign busy_o = use8 ? bus8.busy           : bus32.busy;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    bit ov, exc, ne, lt;
  } exp_t;

  // Reference: signed arithmetic on w-bit values held in 64-bit integers.
  function automatic exp_t model(input int w, input int op, input logic [31:0] ar,
                                 input logic [31:0] br, input int sh);
    longint one, mask, a, b, r, mx, mn;
    exp_t e;
    one  = 1;
    mask = (one << w) - 1;
    mx   = (one << (w - 1)) - 1;
    mn   = -(one << (w - 1));
    a = longint'(ar) & mask; if (a > mx) a = a - (one << w);
    b = longint'(br) & mask; if (b > mx) b = b - (one << w);
    e = '{default: 0};
    case (op)
      1: begin r = a - b; e.ov = (r > mx) || (r < mn); end
      2: r = a & b;
      3: r = a | b;
      4: r = (sh >= w) ? 0 : (a << sh);
      5: r = (sh >= w) ? ((a < 0) ? -1 : 0) : (a >>> sh);
      6: begin r = a * b; e.ov = (r > mx) || (r < mn); end
      7: begin
        if (b == 0) begin r = 0; e.exc = 1; end
        else begin r = a / b; e.ov = r > mx; end
      end
      default: begin r = a + b; e.ov = (r > mx) || (r < mn); end
    endcase
    e.res = 32'(r & mask);
    e.ne  = a != b;
    e.lt  = a < b;
    return e;
  endfunction

  task automatic do_op(input string name, input bit w8, input int op,
                       input logic [31:0] a, input logic [31:0] b, input int sh,
                       input logic [31:0] eres, input bit eov, input bit eexc,
                       input bit ene, input bit elt);
    int lat, w;
    bit md, bsy;
    w  = w8 ? 8 : 32;
    md = (op == 6) || (op == 7);
    use8 = w8; a_in = a; b_in = b; op_in = 5'(op); sh_in = 5'(sh); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    lat = 0;
    bsy = busy_o;
    while (!rdy_o && lat < 200) begin
      @(posedge clock); #1 lat++;
      if (busy_o && !rdy_o) bsy = 1'b1;
    end
    check({name, ".latency"}, 64'(lat), md ? 64'(w + 2) : 64'd0);
    check({name, ".busy"}, 64'(bsy), 64'(md));
    check({name, ".result"}, 64'(res_o), 64'(eres));
    check({name, ".overflow"}, 64'(ov_o), 64'(eov));
    check({name, ".exception"}, 64'(exc_o), 64'(eexc));
    check({name, ".noteq"}, 64'(ne_o), 64'(ene));
    check({name, ".less"}, 64'(lt_o), 64'(elt));
    @(posedge clock); #1;
    check({name, ".rdy_pulse"}, 64'(rdy_o), 64'd0);
    check({name, ".held"}, 64'(res_o), 64'(eres));
  endtask

  typedef struct {
    string name; int op; logic [31:0] a, b; int sh;
    logic [31:0] res; bit ov, exc, ne, lt;
  } vec_t;
  vec_t vecs[13];

  initial begin
    int lat, op, sh, tmp;
    bit seen;
    logic [31:0] a, b;
    exp_t e;

    vecs[0]  = '{"add_ovf",  0, 32'h7FFFFFFF, 32'h1,        0,  32'h80000000, 1, 0, 1, 0};
    vecs[1]  = '{"sub_ovf",  1, 32'h80000000, 32'h1,        0,  32'h7FFFFFFF, 1, 0, 1, 1};
    vecs[2]  = '{"sub_eq",   1, 32'd5,        32'd5,        0,  32'h0,        0, 0, 0, 0};
    vecs[3]  = '{"sra",      5, 32'h80000000, 32'h0,        4,  32'hF8000000, 0, 0, 1, 1};
    vecs[4]  = '{"sll",      4, 32'h1,        32'h0,        31, 32'h80000000, 0, 0, 1, 0};
    vecs[5]  = '{"mul_neg",  6, -32'sd6,      32'd7,        0,  32'hFFFFFFD6, 0, 0, 1, 1};
    vecs[6]  = '{"mul_ovf",  6, 32'h10000,    32'h10000,    0,  32'h0,        1, 0, 0, 0};
    vecs[7]  = '{"div_neg",  7, -32'sd7,      32'd2,        0,  32'hFFFFFFFD, 0, 0, 1, 1};
    vecs[8]  = '{"div_zero", 7, 32'd5,        32'd0,        0,  32'h0,        0, 1, 1, 0};
    vecs[9]  = '{"div_min",  7, 32'h80000000, 32'hFFFFFFFF, 0,  32'h80000000, 1, 0, 1, 1};
    vecs[10] = '{"and",      2, 32'hF0F0,     32'hFF00,     0,  32'hF000,     0, 0, 1, 1};
    vecs[11] = '{"or",       3, 32'hF0F0,     32'hFF00,     0,  32'hFFF0,     0, 0, 1, 1};
    vecs[12] = '{"op9_add",  9, 32'd2,        32'd3,        0,  32'd5,        0, 0, 1, 1};

    use8 = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_in = '0; sh_in = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset.result", 64'(res_o), 64'd0);
    check("reset.flags", 64'({ov_o, exc_o, ne_o, lt_o}), 64'd0);
    check("reset.rdy_busy", 64'({rdy_o, busy_o}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op(vecs[i].name, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
            vecs[i].res, vecs[i].ov, vecs[i].exc, vecs[i].ne, vecs[i].lt);

    // Reset ten edges into a multiply: no RDY, everything cleared.
    use8 = 1'b0; a_in = 32'd7; b_in = 32'd9; op_in = 5'd6; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    seen = 1'b0;
    repeat (9) begin @(posedge clock); #1 if (rdy_o) seen = 1'b1; end
    reset = 1'b1;
    #1;
    check("abort.result", 64'(res_o), 64'd0);
    check("abort.flags", 64'({ov_o, exc_o, ne_o, lt_o}), 64'd0);
    check("abort.rdy_busy", 64'({rdy_o, busy_o}), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (40) begin @(posedge clock); #1 if (rdy_o) seen = 1'b1; end
    check("abort.no_rdy", 64'(seen), 64'd0);
    do_op("add_after_abort", 1'b0, 0, 32'd5, 32'd3, 0, 32'd8, 0, 0, 1, 0);

    // Start held through busy with a different op and operands is ignored.
    a_in = 32'd100; b_in = 32'd7; op_in = 5'd7; start = 1'b1;
    @(posedge clock); #1;
    a_in = 32'd1; b_in = 32'd1; op_in = 5'd0;
    lat = 0; seen = 1'b0;
    repeat (20) begin @(posedge clock); #1 lat++; if (rdy_o) seen = 1'b1; end
    start = 1'b0;
    while (!rdy_o && lat < 200) begin @(posedge clock); #1 lat++; end
    check("ignore.early_rdy", 64'(seen), 64'd0);
    check("ignore.latency", 64'(lat), 64'd34);
    check("ignore.result", 64'(res_o), 64'd14);
    check("ignore.less", 64'(lt_o), 64'd0);

    // Start in the RDY cycle is accepted back-to-back.
    a_in = 32'd3; b_in = 32'd4; op_in = 5'd6; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    lat = 0;
    while (!rdy_o && lat < 200) begin @(posedge clock); #1 lat++; end
    check("b2b.first", 64'(res_o), 64'd12);
    a_in = -32'sd5; b_in = 32'd5; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    lat = 0;
    while (!rdy_o && lat < 200) begin @(posedge clock); #1 lat++; end
    check("b2b.latency", 64'(lat), 64'd34);
    check("b2b.result", 64'(res_o), 64'hFFFFFFE7);

    // Start held in IDLE issues one single-cycle op per edge.
    op_in = 5'd0; b_in = 32'd2; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in = 32'(10 + i);
      @(posedge clock); #1;
      check("stream.rdy", 64'(rdy_o), 64'd1);
      check("stream.result", 64'(res_o), 64'(12 + i));
    end
    start = 1'b0;
    @(posedge clock); #1;
    check("stream.idle", 64'(rdy_o), 64'd0);

    do_op("mul8_neg", 1'b1, 6, -32'sd6, 32'd7, 0, 32'hD6, 0, 0, 1, 1);
    do_op("mul8_ovf", 1'b1, 6, 32'h10, 32'h10, 0, 32'h0, 1, 0, 0, 0);

    for (int i = 0; i < 240; i++) begin
      op = int'($urandom_range(0, 9));
      a  = $urandom;
      b  = $urandom;
      sh = int'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        tmp = int'($urandom_range(0, 8)) - 4;
        b = 32'(tmp);
      end
      if (i < 200) begin
        e = model(32, op, a, b, sh);
        do_op($sformatf("rand32_%0d_op%0d", i, op), 1'b0, op, a, b, sh,
              e.res, e.ov, e.exc, e.ne, e.lt);
      end else begin
        e = model(8, op, a, b, sh % 8);
        do_op($sformatf("rand8_%0d_op%0d", i, op), 1'b1, op, a, b, sh,
              e.res, e.ov, e.exc, e.ne, e.lt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
